// File: rtl/sprite_reg_commit.sv
// Vblank-synchronised commit scheduler: host writes to sprite/score position registers
// are queued and applied only during vertical blanking, so the display never tears.
module sprite_reg_commit #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NREGS   = 12,
  parameter int unsigned VACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [8:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic        reg_we,
  output logic [3:0]  reg_addr,
  output logic [7:0]  reg_data,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [8:0] StatusAddr = 9'h100;
  localparam logic [8:0] CtrlAddr   = 9'h101;

  typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [11:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          vblank_q;
  logic [15:0]   frame_count_q;
  logic          overflow_q, irq_q;
  logic          reg_we_q;
  logic [3:0]    reg_addr_q;
  logic [7:0]    reg_data_q;
  logic [31:0]   readdata_q;

  logic        wr_en, push_req, ctrl_wr, vblank, vb_rise;
  logic        empty, full, pop, push, irq_set, overflow_set;
  logic [11:0] head;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:8];

  assign wr_en    = chipselect & write;
  assign push_req = wr_en & (address < 9'(NREGS));
  assign ctrl_wr  = wr_en & (address == CtrlAddr);
  assign vblank   = (vcount >= 10'(VACTIVE));
  assign vb_rise  = vblank & ~vblank_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign head     = mem_q[rd_ptr_q];

  // Full is judged after a same-cycle pop, so a push into a draining full FIFO is kept.
  assign push         = push_req & (~full | pop);
  assign overflow_set = push_req & full & ~pop;
  assign count_d      = count_q + CW'(push) - CW'(pop);

  assign status = {overflow_q, irq_q, 7'b0, 7'(count_q), frame_count_q};

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    irq_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (vb_rise) state_d = StDrain;
      end
      StDrain: begin
        if (!vblank) begin
          state_d = StIdle;
        end else if (empty) begin
          state_d = StDone;
          irq_set = 1'b1;
        end else begin
          pop = 1'b1;
        end
      end
      StDone: begin
        if (!vblank) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {address[3:0], writedata[7:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      vblank_q      <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      irq_q         <= 1'b0;
      reg_we_q      <= 1'b0;
      reg_addr_q    <= '0;
      reg_data_q    <= '0;
      readdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      vblank_q      <= vblank;
      frame_count_q <= frame_count_q + 16'(vb_rise);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      // Sets win over a same-cycle clear so no event is lost.
      overflow_q <= overflow_set | (overflow_q & ~(ctrl_wr & writedata[0]));
      irq_q      <= irq_set | (irq_q & ~(ctrl_wr & writedata[1]));
      reg_we_q   <= pop;
      if (pop) begin
        reg_addr_q <= head[11:8];
        reg_data_q <= head[7:0];
      end
      if (chipselect & read) begin
        readdata_q <= (address == StatusAddr) ? status : '0;
      end
    end
  end

  assign readdata = readdata_q;
  assign reg_we   = reg_we_q;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign irq      = irq_q;

endmodule
